// File: rtl/io_bus_bridge.sv
// Bus bridge behind the core's MEM stage: splits accesses between the sync data RAM
// and a memory-mapped IO page (display, LEDs, switches, buttons, timer).
module io_bus_bridge #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int CTRL_W   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [CTRL_W-1:0] bus_ctrl,
  input  logic [DATA_W-1:0] bus_wd,
  input  logic              bus_we,
  output logic [DATA_W-1:0] bus_rd,
  output logic [ADDR_W-3:0] dram_addr,
  output logic [DATA_W-1:0] dram_wd,
  output logic [CTRL_W-1:0] dram_be,
  output logic              dram_we,
  input  logic [DATA_W-1:0] dram_rd,
  input  logic [23:0]       sw,
  input  logic [4:0]        btn,
  output logic [23:0]       led,
  output logic [7:0]        dig_en,
  output logic [7:0]        seg
);

  localparam logic [9:0] OFF_DISP = 10'h000;
  localparam logic [9:0] OFF_TVAL = 10'h008;
  localparam logic [9:0] OFF_TDIV = 10'h009;
  localparam logic [9:0] OFF_LED  = 10'h018;
  localparam logic [9:0] OFF_SW   = 10'h01C;
  localparam logic [9:0] OFF_BTN  = 10'h01E;

  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);

  typedef enum logic [2:0] {D0, D1, D2, D3, D4, D5, D6, D7} dig_e;

  function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] old,
                                                 input logic [DATA_W-1:0] wd,
                                                 input logic [CTRL_W-1:0] be);
    logic [DATA_W-1:0] r;
    r = old;
    for (int i = 0; i < CTRL_W; i++)
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40; 4'h1: hex7 = 7'h79; 4'h2: hex7 = 7'h24; 4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19; 4'h5: hex7 = 7'h12; 4'h6: hex7 = 7'h02; 4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00; 4'h9: hex7 = 7'h10; 4'hA: hex7 = 7'h08; 4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46; 4'hD: hex7 = 7'h21; 4'hE: hex7 = 7'h06; default: hex7 = 7'h0E;
    endcase
  endfunction

  logic              io_hit;
  logic [9:0]        word;
  logic              wr_io, wr_disp, wr_tval, wr_tdiv, wr_led;
  logic [DATA_W-1:0] disp, tmr_val, tmr_div, pcnt, div_eff;
  logic              tick;
  logic [DATA_W-1:0] led_wr, io_rdata, io_rdata_q;
  logic              region_q;
  logic [23:0]       sw_s1, sw_s2;
  logic [4:0]        btn_s1, btn_s2;
  logic [SCW-1:0]    scan_cnt;
  dig_e              dig;

  assign io_hit    = &bus_addr[ADDR_W-1:12];
  assign word      = bus_addr[11:2];
  assign dram_addr = bus_addr[ADDR_W-1:2];
  assign dram_wd   = bus_wd;
  assign dram_be   = bus_ctrl;
  assign dram_we   = bus_we & ~io_hit;

  assign wr_io   = bus_we & io_hit;
  assign wr_disp = wr_io & (word == OFF_DISP);
  assign wr_tval = wr_io & (word == OFF_TVAL);
  assign wr_tdiv = wr_io & (word == OFF_TDIV);
  assign wr_led  = wr_io & (word == OFF_LED);

  assign led_wr = be_merge({{(DATA_W-24){1'b0}}, led}, bus_wd, bus_ctrl);
  wire unused_bits = ^{bus_addr[1:0], led_wr[DATA_W-1:24]};

  always_comb begin
    io_rdata = '0;
    case (word)
      OFF_DISP: io_rdata = disp;
      OFF_TVAL: io_rdata = tmr_val;
      OFF_TDIV: io_rdata = tmr_div;
      OFF_LED:  io_rdata = {{(DATA_W-24){1'b0}}, led};
      OFF_SW:   io_rdata = {{(DATA_W-24){1'b0}}, sw_s2};
      OFF_BTN:  io_rdata = {{(DATA_W-5){1'b0}}, btn_s2};
      default:  io_rdata = '0;
    endcase
  end

  // region_q resets to the IO side so bus_rd reads 0 in reset without consulting dram_rd
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      region_q   <= 1'b1;
      io_rdata_q <= '0;
    end else begin
      region_q   <= io_hit;
      io_rdata_q <= io_rdata;
    end
  end

  assign bus_rd = region_q ? io_rdata_q : dram_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp <= '0;
      led  <= '0;
    end else begin
      if (wr_disp) disp <= be_merge(disp, bus_wd, bus_ctrl);
      if (wr_led)  led  <= led_wr[23:0];
    end
  end

  // Divider of 0 behaves as 1 so the timer never stalls
  assign div_eff = (tmr_div == '0) ? DATA_W'(1) : tmr_div;
  assign tick    = (pcnt == div_eff - DATA_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_val <= '0;
      tmr_div <= '0;
      pcnt    <= '0;
    end else begin
      if (wr_tdiv) tmr_div <= be_merge(tmr_div, bus_wd, bus_ctrl);
      if (wr_tdiv || tick) pcnt <= '0;
      else                 pcnt <= pcnt + DATA_W'(1);
      if (wr_tval)   tmr_val <= be_merge(tmr_val, bus_wd, bus_ctrl);
      else if (tick) tmr_val <= tmr_val + DATA_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      dig      <= D0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      dig      <= dig_e'(dig + 3'd1);
    end else begin
      scan_cnt <= scan_cnt + SCW'(1);
    end
  end

  assign dig_en = ~(8'b1 << dig);
  assign seg    = {1'b1, hex7(disp[4*dig +: 4])};

endmodule

// File: tb/tb_io_bus_bridge.sv
// Self-checking bench for io_bus_bridge: vector table with a read-response scoreboard,
// plus hand sequences for reset, synchroniser latency, timer and display scan.
module tb_io_bus_bridge;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] bus_addr, bus_wd, bus_rd, dram_wd, dram_rd;
  logic [3:0]  bus_ctrl, dram_be;
  logic        bus_we, dram_we;
  logic [29:0] dram_addr;
  logic [23:0] sw, led;
  logic [4:0]  btn;
  logic [7:0]  dig_en, seg;

  always #5 clk = ~clk;

  io_bus_bridge #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_ctrl(bus_ctrl), .bus_wd(bus_wd),
    .bus_we(bus_we), .bus_rd(bus_rd), .dram_addr(dram_addr), .dram_wd(dram_wd),
    .dram_be(dram_be), .dram_we(dram_we), .dram_rd(dram_rd), .sw(sw), .btn(btn),
    .led(led), .dig_en(dig_en), .seg(seg)
  );

  int errs = 0;
  int checks = 0;
  logic [31:0] q[$];
  logic [7:0] segtab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  ctrl;
    logic [31:0] wd;
    logic [31:0] ram;
    logic [31:0] exp_rd;
    logic        exp_dwe;
    logic [23:0] exp_led;
  } vec_t;
  vec_t v[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [3:0] c,
                       input logic [31:0] d);
    bus_we = we; bus_addr = a; bus_ctrl = c; bus_wd = d;
  endtask

  initial begin
    v[0]  = '{1'b1, 32'hFFFFF060, 4'b0011, 32'h00ABCDEF, 32'h0,        32'h0,        1'b0, 24'h00CDEF};
    v[1]  = '{1'b0, 32'hFFFFF060, 4'b1111, 32'h0,        32'h0,        32'h0000CDEF, 1'b0, 24'h00CDEF};
    v[2]  = '{1'b0, 32'hFFFFF070, 4'b1111, 32'h0,        32'h0,        32'h005A5A5A, 1'b0, 24'h00CDEF};
    v[3]  = '{1'b0, 32'hFFFFF078, 4'b1111, 32'h0,        32'h0,        32'h00000015, 1'b0, 24'h00CDEF};
    v[4]  = '{1'b0, 32'hFFFFF0F0, 4'b1111, 32'h0,        32'h0,        32'h0,        1'b0, 24'h00CDEF};
    v[5]  = '{1'b1, 32'hFFFFF0F0, 4'b1111, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b0, 24'h00CDEF};
    v[6]  = '{1'b1, 32'hFFFFF070, 4'b1111, 32'h0,        32'h0,        32'h005A5A5A, 1'b0, 24'h00CDEF};
    v[7]  = '{1'b0, 32'hFFFFF070, 4'b1111, 32'h0,        32'h0,        32'h005A5A5A, 1'b0, 24'h00CDEF};
    v[8]  = '{1'b1, 32'h00000100, 4'b1111, 32'h11111111, 32'hAAAA0001, 32'hAAAA0001, 1'b1, 24'h00CDEF};
    v[9]  = '{1'b0, 32'hFFFFF000, 4'b1111, 32'h0,        32'h0,        32'h0,        1'b0, 24'h00CDEF};
    v[10] = '{1'b1, 32'h00000104, 4'b0001, 32'h22222222, 32'hBBBB0002, 32'hBBBB0002, 1'b1, 24'h00CDEF};
    v[11] = '{1'b0, 32'hFFFFF060, 4'b1111, 32'h0,        32'h0,        32'h0000CDEF, 1'b0, 24'h00CDEF};
    v[12] = '{1'b1, 32'h00000108, 4'b1111, 32'h33333333, 32'hCCCC0003, 32'hCCCC0003, 1'b1, 24'h00CDEF};
    v[13] = '{1'b0, 32'hFFFFF078, 4'b1111, 32'h0,        32'h0,        32'h00000015, 1'b0, 24'h00CDEF};
    v[14] = '{1'b0, 32'h00000200, 4'b1111, 32'h0,        32'hDDDD0004, 32'hDDDD0004, 1'b0, 24'h00CDEF};
    v[15] = '{1'b1, 32'hFFFFF060, 4'b1100, 32'hFF123456, 32'h0,        32'h0000CDEF, 1'b0, 24'h12CDEF};
    v[16] = '{1'b0, 32'hFFFFF060, 4'b1111, 32'h0,        32'h0,        32'h0012CDEF, 1'b0, 24'h12CDEF};
    v[17] = '{1'b1, 32'hFFFFF000, 4'b0101, 32'h11223344, 32'h0,        32'h0,        1'b0, 24'h12CDEF};
    v[18] = '{1'b0, 32'hFFFFF000, 4'b1111, 32'h0,        32'h0,        32'h00220044, 1'b0, 24'h12CDEF};

    sw = 24'h5A5A5A; btn = 5'h15;
    drive(1'b0, 32'h0, 4'hF, 32'h0);
    dram_rd = 32'h12345678;

    // reset state, then first DRAM read after release
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus_rd", bus_rd, 32'h0);
    chk("rst_dig_en", {24'h0, dig_en}, 32'hFE);
    chk("rst_seg", {24'h0, seg}, 32'hC0);
    chk("rst_led", {8'h0, led}, 32'h0);
    rst_n = 1'b1;
    step();
    chk("first_dram_rd", bus_rd, 32'h12345678);

    foreach (v[i]) begin
      drive(v[i].we, v[i].addr, v[i].ctrl, v[i].wd);
      #1;
      chk($sformatf("dram_we[%0d]", i), {31'h0, dram_we}, {31'h0, v[i].exp_dwe});
      chk($sformatf("dram_addr[%0d]", i), {2'b0, dram_addr}, {2'b0, v[i].addr[31:2]});
      q.push_back(v[i].exp_rd);
      step();
      dram_rd = v[i].ram;
      #1;
      chk($sformatf("bus_rd[%0d]", i), bus_rd, q.pop_front());
      chk($sformatf("led[%0d]", i), {8'h0, led}, {8'h0, v[i].exp_led});
    end

    // switch synchroniser: 2 flops plus 1 cycle read latency
    drive(1'b0, 32'hFFFFF070, 4'hF, 32'h0);
    sw = 24'h123456;
    step(); chk("sw_lat1", bus_rd, 32'h005A5A5A);
    step(); chk("sw_lat2", bus_rd, 32'h005A5A5A);
    step(); chk("sw_lat3", bus_rd, 32'h00123456);

    // timer: divider 3, wrap from all-ones, write colliding with a tick, divider 0
    drive(1'b1, 32'hFFFFF024, 4'hF, 32'd3); step();
    drive(1'b1, 32'hFFFFF020, 4'hF, 32'hFFFFFFFF); step();
    drive(1'b0, 32'hFFFFF020, 4'hF, 32'h0);
    step(); chk("tmr_pre_wrap_a", bus_rd, 32'hFFFFFFFF);
    step(); chk("tmr_pre_wrap_b", bus_rd, 32'hFFFFFFFF);
    step(); chk("tmr_wrapped", bus_rd, 32'h0);
    step(); chk("tmr_hold", bus_rd, 32'h0);
    drive(1'b1, 32'hFFFFF020, 4'hF, 32'd7); step();
    drive(1'b0, 32'hFFFFF020, 4'hF, 32'h0);
    step(); chk("tmr_write_wins", bus_rd, 32'd7);
    drive(1'b1, 32'hFFFFF024, 4'hF, 32'd0); step();
    drive(1'b0, 32'hFFFFF020, 4'hF, 32'h0);
    step(); chk("tmr_div0_a", bus_rd, 32'd7);
    step(); chk("tmr_div0_b", bus_rd, 32'd8);
    step(); chk("tmr_div0_c", bus_rd, 32'd9);

    // asynchronous reset mid-scan, then display scan
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_dig_en", {24'h0, dig_en}, 32'hFE);
    chk("mid_rst_seg", {24'h0, seg}, 32'hC0);
    chk("mid_rst_led", {8'h0, led}, 32'h0);
    chk("mid_rst_bus_rd", bus_rd, 32'h0);
    step();
    rst_n = 1'b1;
    drive(1'b1, 32'hFFFFF000, 4'hF, 32'h76543210);
    for (int k = 1; k <= 40; k++) begin
      logic [7:0] e;
      int d;
      step();
      if (k == 1) drive(1'b0, 32'h0, 4'hF, 32'h0);
      d = (k / 4) % 8;
      e = 8'hFF;
      e[d] = 1'b0;
      chk($sformatf("dig_en[k=%0d]", k), {24'h0, dig_en}, {24'h0, e});
      chk($sformatf("seg[k=%0d]", k), {24'h0, seg}, {24'h0, segtab[d]});
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
